unified_mem_arbiter: RTL
========================

# unified_mem_arbiter

Sequential arbiter that shares one single-ported unified instruction/data memory between the pipeline's instruction-fetch stage and its memory-access stage. Each requester holds a request until it receives a one-cycle acknowledge, and the arbiter drives a multi-cycle memory handshake (`mem_req`/`mem_ready`). It grants data accesses first, with a streak limit that guarantees fetch progress. It produces the stall signals the pipeline registers use to freeze the IF and MEM stages while a request is outstanding.

## Interface
- `ADDR_W`, 8: byte address width for both requesters and memory.
- `DATA_W`, 32: data width.
- `STREAK`, 4: maximum consecutive data grants while a fetch is pending; range 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_ack`  out  1  one-cycle pulse: fetch complete, `if_rdata` valid.
- `if_rdata`  out  DATA_W  fetched word; registered and held until the next fetch ack.
- `d_req`  in  1  data request; held until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  DATA_W  store data.
- `d_funct3`  in  3  access size and sign (RV32 load/store funct3).
- `d_ack`  out  1  one-cycle pulse: data access complete.
- `d_rdata`  out  DATA_W  load data; registered and held until the next data ack.
- `mem_req`  out  1  memory transaction active.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_funct3`  out  1/ADDR_W/DATA_W/3  transaction fields, latched at grant.
- `mem_ready`  in  1  memory completes the transaction this cycle.
- `mem_rdata`  in  DATA_W  read data, valid when `mem_ready`=1.
- `stall_if`  out  1  `if_req & ~if_ack` (combinational).
- `stall_mem`  out  1  `d_req & ~d_ack` (combinational).

## Operation
- FSM states: IDLE, BUSY_D, BUSY_I.
- IDLE: the eligible set is `d_req & ~d_ack` and `if_req & ~if_ack`. A requester is not eligible during its own ack cycle, because its `req` is still high then.
  - Only data eligible → BUSY_D.
  - Only fetch eligible → BUSY_I.
  - Both eligible → BUSY_D, unless `streak == STREAK`; then → BUSY_I.
  - Neither eligible → stay in IDLE.
- On the grant edge, register the memory fields:
  - Data grant: `mem_we=d_we`, `mem_addr=d_addr`, `mem_wdata=d_wdata`, `mem_funct3=d_funct3`.
  - Fetch grant: `mem_we=0`, `mem_addr=if_addr`, `mem_wdata=0`, `mem_funct3=3'b010`.
- BUSY_x: `mem_req=1` and all fields are stable. On an edge with `mem_ready=1`:
  - Go to IDLE.
  - Pulse `x_ack` for the next cycle.
  - Capture `mem_rdata` into `x_rdata`. For stores, `d_rdata` is left unchanged.
- Streak counter (4 bits):
  - A data grant with `if_req=1` increments the counter, saturating at `STREAK`.
  - A data grant with `if_req=0` clears it to 0.
  - A fetch grant clears it to 0.
- A requester dropping `req` while BUSY is a protocol violation. The transaction still completes and the ack still pulses.
- `mem_ready` while in IDLE is ignored.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; `mem_req`, `mem_we`, `if_ack`, `d_ack` = 0; `mem_addr`, `mem_wdata`, `mem_funct3`, `if_rdata`, `d_rdata`, streak = 0.
- Reset mid-transaction: the transaction is abandoned with no ack. `mem_req` falls asynchronously.
- Latency: `req` rises in cycle 0 → `mem_req` high from cycle 1 → `mem_ready` in cycle k≥1 → ack in cycle k+1.
  - Minimum request-to-ack latency is 2 cycles.
  - There is 1 IDLE cycle between back-to-back transactions; that cycle is the ack cycle. A new grant can occur in the ack cycle for the other requester.
- Memory side: `mem_req` and the transaction fields are driven only from registers, with no combinational path from requester inputs.
- `stall_*` is the only combinational output.

## Structure
- Package `mem_arb_pkg`:
  - State enum `arb_state_t` {IDLE, BUSY_D, BUSY_I}.
  - `FUNCT3_LW = 3'b010`.
  - Default `STREAK`.
- One sub-module, `mem_arb_pick`: combinational grant choice from the eligible set and streak, plus the registered streak counter.
- The FSM, field registers and read-data registers stay in `unified_mem_arbiter`.

## Test plan
- Fetch only: `if_req` with `if_addr=0x10`; memory returns `0x00A00093` with `mem_ready` in the first busy cycle → `mem_funct3=010`, `mem_we=0`, `if_ack` in cycle 2, `if_rdata=0x00A00093`, `stall_if` low after the ack.
- Simultaneous requests: `d_req` store (`d_addr=0x20`, `d_wdata=0xDEADBEEF`, `d_funct3=000`) and `if_req` in the same cycle → data granted first with `mem_wdata=0xDEADBEEF`, `d_ack`; then fetch granted in the ack cycle; `if_ack` 2 cycles later.
- Starvation guard: `STREAK=4`, `d_req` re-asserted continuously and `if_req` held → grant sequence D,D,D,D,I,D…; streak returns to 0 after the fetch grant.
- Wait states: `mem_ready` delayed 3 cycles → `mem_addr` and the other fields are stable for all 3 cycles, `stall_mem` is high for 4 cycles, and `d_ack` fires exactly once.
- Reset mid-op: assert `rst`=0 during BUSY_D → `mem_req` drops immediately, no ack; after release with `if_req` held, the fetch is granted normally.
- Load then store: load returns `0x1234` into `d_rdata`; a following store does not alter `d_rdata` (still `0x1234`).

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory arbiter.
//   arb_state_t    : arbiter FSM states
//   FUNCT3_LW      : funct3 presented to memory for instruction fetches
//   STREAK_DEFAULT : default limit on back-to-back data grants while a fetch waits
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_D = 2'd1,
      BUSY_I = 2'd2
   } arb_state_t;

   localparam logic [2:0] FUNCT3_LW      = 3'b010;
   localparam int         STREAK_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection for the unified memory arbiter.
// Data is preferred, except when the streak counter has reached its limit
// and a fetch is also eligible. The streak counter lives here as well.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   idle            : arbiter is free to grant this cycle
//   d_elig, i_elig  : data / fetch requester eligible for a grant
//   if_req          : raw fetch request (drives the streak rule)
//   grant_d, grant_i: one-hot grant decision (combinational)
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STREAK = STREAK_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic idle,
   input  logic d_elig,
   input  logic i_elig,
   input  logic if_req,
   output logic grant_d,
   output logic grant_i
);

   localparam logic [3:0] STREAK_MAX = 4'(STREAK);

   logic [3:0] streak;
   logic       at_limit;

   assign at_limit = (streak == STREAK_MAX);

   always_comb begin
      grant_d = 1'b0;
      grant_i = 1'b0;
      if (idle) begin
         if (d_elig && !(i_elig && at_limit))
            grant_d = 1'b1;
         else if (i_elig)
            grant_i = 1'b1;
      end
   end

   // The raw if_req (not eligibility) decides whether a data grant counts
   // against the fetch, so a fetch sitting in its ack cycle still advances it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         streak <= '0;
      else if (grant_i)
         streak <= '0;
      else if (grant_d) begin
         if (!if_req)
            streak <= '0;
         else if (!at_limit)
            streak <= streak + 4'd1;
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported unified memory between instruction fetch and
// data access. Requesters hold req until a one-cycle ack; the memory side
// is a req/ready handshake whose fields are registered at grant.
// Ports:
//   clk, rst                         : clock, asynchronous active-low reset
//   if_req/if_addr/if_ack/if_rdata   : fetch requester
//   d_req/d_we/d_addr/d_wdata/d_funct3/d_ack/d_rdata : data requester
//   mem_req/mem_we/mem_addr/mem_wdata/mem_funct3     : registered memory request
//   mem_ready/mem_rdata              : memory completion and read data
//   stall_if, stall_mem              : pipeline freeze (combinational)
//
// state  | meaning
// IDLE   | memory free; grant chosen from the eligible requesters
// BUSY_D | data transaction in flight, waiting for mem_ready
// BUSY_I | fetch transaction in flight, waiting for mem_ready
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int STREAK = STREAK_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [2:0]        d_funct3,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_funct3,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   arb_state_t state, state_nxt;
   logic       grant_d, grant_i;
   logic       d_elig, i_elig;

   // A requester still holds req during its ack cycle; it must not be re-granted then.
   assign d_elig    = d_req & ~d_ack;
   assign i_elig    = if_req & ~if_ack;
   assign stall_mem = d_req & ~d_ack;
   assign stall_if  = if_req & ~if_ack;

   mem_arb_pick #(
      .STREAK (STREAK)
   ) u_pick (
      .clk     (clk),
      .rst     (rst),
      .idle    (state == IDLE),
      .d_elig  (d_elig),
      .i_elig  (i_elig),
      .if_req  (if_req),
      .grant_d (grant_d),
      .grant_i (grant_i)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_d)
               state_nxt = BUSY_D;
            else if (grant_i)
               state_nxt = BUSY_I;
         end
         BUSY_D, BUSY_I: begin
            if (mem_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // mem_req is its own flop so the memory never sees requester-side logic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_funct3 <= '0;
      end else begin
         mem_req <= (state_nxt != IDLE);
         if (grant_d) begin
            mem_we     <= d_we;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            mem_funct3 <= d_funct3;
         end else if (grant_i) begin
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_funct3 <= FUNCT3_LW;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_ack    <= 1'b0;
         if_ack   <= 1'b0;
         d_rdata  <= '0;
         if_rdata <= '0;
      end else begin
         d_ack  <= (state == BUSY_D) && mem_ready;
         if_ack <= (state == BUSY_I) && mem_ready;
         if ((state == BUSY_D) && mem_ready && !mem_we)
            d_rdata <= mem_rdata;
         if ((state == BUSY_I) && mem_ready)
            if_rdata <= mem_rdata;
      end
   end

endmodule
